pilot_insert: RTL and testbench

Transmit-side pilot insertion for the 802.16 OFDM chain. Takes a stream of 192 data subcarriers per symbol from the mapper and emits 200-word symbols for the IFFT/subcarrier-mapping stage: 8 BPSK pilots first, then the 192 data words unchanged. Pilot signs come from the same 128-bit pilot sequence the receiver's phase tracker expects, so the receiver can de-rotate with pilot words 0..7 of each symbol. Wishbone-style streaming on both sides, matching the rest of the datapath.

---
 rtl/pilot_insert_pkg.sv | 27 ++
 rtl/pilot_seq_gen.sv | 31 +++
 rtl/pilot_insert.sv | 140 ++++++++++++++
 tb/tb_pilot_insert.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pilot_insert_pkg.sv
// Shared constants, state type and pilot helpers for the transmit pilot inserter.
package pilot_insert_pkg;

  // Word counts per OFDM symbol
  localparam int unsigned N_PIL = 8;
  localparam int unsigned N_DAT = 192;

  // BPSK pilot real parts, +/-1/sqrt(2) in Q3.13
  localparam logic [15:0] P_P = 16'h16A1;
  localparam logic [15:0] P_N = 16'hE95F;

  // Pilot sign sequence, bit i = 1 means pilot i is negative. Must match the
  // receiver's pilot file contents bit for bit.
  localparam logic [127:0] PIL_SEQ = 128'hF3A5_0C7E_9B21_D468_5E0F_A3C9_71B4_2D86;

  typedef enum logic [1:0] {
    StIdle,
    StPilot,
    StData
  } state_e;

  // Full 32-bit pilot subcarrier word, imaginary part always zero
  function automatic logic [31:0] pilot_word(input logic sign);
    return {16'h0000, (sign ? P_N : P_P)};
  endfunction

endpackage

// File: rtl/pilot_seq_gen.sv
// Pilot sign generator: walks PIL_SEQ with a 7-bit index that wraps every 16 symbols.
module pilot_seq_gen
  import pilot_insert_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic advance_i,
  output logic sign_o
);

  logic [6:0] idx_q, idx_d;
  logic [6:0] idx_eff;

  // Clear takes effect in the same cycle so a start can emit pilot 0 immediately
  always_comb begin
    idx_eff = clear_i ? 7'd0 : idx_q;
    sign_o  = PIL_SEQ[idx_eff];
    idx_d   = advance_i ? idx_eff + 7'd1 : idx_eff;
  end

  // Index register, wraps 127 -> 0 naturally
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= 7'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/pilot_insert.sv
// Transmit pilot insertion: 8 BPSK pilots followed by 192 data words per symbol.
module pilot_insert
  import pilot_insert_pkg::*;
(
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] DAT_I,
  input  logic        WE_I,
  input  logic        STB_I,
  input  logic        CYC_I,
  output logic        ACK_O,
  output logic [31:0] DAT_O,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  input  logic        ACK_I
);

  localparam logic [7:0] LastPil = 8'(N_PIL - 1);
  localparam logic [7:0] LastDat = 8'(N_DAT - 1);

  state_e      state_q, state_d, state_eff;
  logic [7:0]  cnt_q, cnt_d, cnt_eff;
  logic [31:0] dat_q, dat_d;
  logic        stb_q, stb_d;
  logic        cyc_o_q, cyc_o_d;
  logic        cyc_prev_q;

  logic datin_val, out_halt, istart;
  logic ack;
  logic pil_clr, pil_adv, pil_sign;

  // Handshake qualifiers
  always_comb begin
    datin_val = WE_I & STB_I & CYC_I;
    out_halt  = stb_q & ~ACK_I;
    istart    = CYC_I & ~cyc_prev_q;
  end

  pilot_seq_gen u_pilot_seq_gen (
    .clk_i    (CLK_I),
    .rst_ni   (RST_I),
    .clear_i  (pil_clr),
    .advance_i(pil_adv),
    .sign_o   (pil_sign)
  );

  // Next-state, output register loads and input acknowledge
  always_comb begin
    // A start overrides the registered state and counter in its own cycle,
    // so pilot 0 is emitted there and appears on DAT_O one cycle later.
    state_eff = istart ? StPilot : state_q;
    cnt_eff   = istart ? 8'd0 : cnt_q;
    state_d   = state_eff;
    cnt_d     = cnt_eff;
    dat_d     = dat_q;
    stb_d     = out_halt ? stb_q : 1'b0;
    ack       = 1'b0;
    pil_clr   = istart;
    pil_adv   = 1'b0;

    unique case (state_eff)
      StIdle: begin
      end
      StPilot: begin
        if (!CYC_I) begin
          state_d = StIdle;
        end else if (!out_halt) begin
          dat_d   = pilot_word(pil_sign);
          stb_d   = 1'b1;
          pil_adv = 1'b1;
          if (cnt_eff == LastPil) begin
            cnt_d   = 8'd0;
            state_d = StData;
          end else begin
            cnt_d = cnt_eff + 8'd1;
          end
        end
      end
      StData: begin
        if (!CYC_I) begin
          state_d = StIdle;
        end else begin
          ack = datin_val & ~out_halt;
          if (ack) begin
            dat_d = DAT_I;
            stb_d = 1'b1;
            if (cnt_eff == LastDat) begin
              // CYC_I is known high here, so the burst continues
              cnt_d   = 8'd0;
              state_d = StPilot;
            end else begin
              cnt_d = cnt_eff + 8'd1;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase

    // Downstream cycle stays up until the last word has drained
    if (istart) begin
      cyc_o_d = 1'b1;
    end else if ((state_q == StIdle) && !CYC_I && !stb_q) begin
      cyc_o_d = 1'b0;
    end else begin
      cyc_o_d = cyc_o_q;
    end
  end

  // State and output registers
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      dat_q      <= 32'd0;
      stb_q      <= 1'b0;
      cyc_o_q    <= 1'b0;
      // Resets high so a burst already active at release is not a start
      cyc_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dat_q      <= dat_d;
      stb_q      <= stb_d;
      cyc_o_q    <= cyc_o_d;
      cyc_prev_q <= CYC_I;
    end
  end

  assign ACK_O = ack;
  assign DAT_O = dat_q;
  assign STB_O = stb_q;
  assign CYC_O = cyc_o_q;
  assign WE_O  = cyc_o_q;

endmodule

// File: tb/tb_pilot_insert.sv
// Self-checking bench for pilot_insert.
module tb_pilot_insert;

  localparam logic [127:0] PSEQ = 128'hF3A5_0C7E_9B21_D468_5E0F_A3C9_71B4_2D86;
  localparam logic [31:0]  WP   = 32'h0000_16A1;
  localparam logic [31:0]  WN   = 32'h0000_E95F;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [31:0] DAT_I;
  logic        WE_I, STB_I, CYC_I, ACK_I;
  logic        ACK_O, CYC_O, STB_O, WE_O;
  logic [31:0] DAT_O;

  pilot_insert dut (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .DAT_I(DAT_I),
    .WE_I (WE_I),
    .STB_I(STB_I),
    .CYC_I(CYC_I),
    .ACK_O(ACK_O),
    .DAT_O(DAT_O),
    .CYC_O(CYC_O),
    .STB_O(STB_O),
    .WE_O (WE_O),
    .ACK_I(ACK_I)
  );

  always #5 CLK_I = ~CLK_I;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] cap_q[$];
  int          src_idx = 0;

  typedef struct {
    int          pos;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];
  vec_t tbl_s1[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int w);
    logic [15:0] a;
    a = 16'(w);
    return {a, -a};
  endfunction

  function automatic logic [31:0] pil(input int idx);
    logic [127:0] s;
    s = PSEQ;
    return s[idx] ? WN : WP;
  endfunction

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  // Output monitor and source bookkeeping, sampled on the falling edge
  initial begin
    logic        prev_ack, prev_hold;
    logic [31:0] prev_din, prev_dout;
    prev_ack  = 1'b0;
    prev_hold = 1'b0;
    prev_din  = '0;
    prev_dout = '0;
    forever begin
      @(negedge CLK_I);
      if (!RST_I) begin
        prev_ack  = 1'b0;
        prev_hold = 1'b0;
      end else begin
        if (prev_ack) begin
          check("ack_then_stb", {31'd0, STB_O}, 32'd1);
          check("ack_then_dout", DAT_O, prev_din);
        end
        if (prev_hold) begin
          check("halt_stb_hold", {31'd0, STB_O}, 32'd1);
          check("halt_dout_hold", DAT_O, prev_dout);
        end
        if (STB_O && ACK_I) cap_q.push_back(DAT_O);
        if (ACK_O) src_idx++;
        prev_ack  = ACK_O;
        prev_din  = DAT_I;
        prev_hold = STB_O & ~ACK_I;
        prev_dout = DAT_O;
      end
    end
  end

  // One burst of n_words data words; pilots expected from index 0
  task automatic run_burst(input int n_words, input int stall, input int gap,
                           output int first_ack, output int first_stb, output logic cyc_at1);
    int pidx;
    int cyc;
    pidx = 0;
    src_q.delete();
    exp_q.delete();
    cap_q.delete();
    src_idx   = 0;
    first_ack = -1;
    first_stb = -1;
    cyc_at1   = 1'b0;
    for (int w = 0; w < n_words; w++) begin
      if (w % 192 == 0) begin
        for (int j = 0; j < 8; j++) begin
          exp_q.push_back(pil(pidx));
          pidx = (pidx + 1) % 128;
        end
      end
      src_q.push_back(mk(w));
      exp_q.push_back(mk(w));
    end
    cyc   = 0;
    CYC_I = 1'b1;
    while (src_idx < n_words && cyc < 20000) begin
      STB_I = ($urandom_range(99) >= gap);
      ACK_I = ($urandom_range(99) >= stall);
      DAT_I = src_q[src_idx];
      #1;
      if (ACK_O && first_ack < 0) first_ack = cyc;
      if (STB_O && first_stb < 0) first_stb = cyc;
      if (cyc == 1) cyc_at1 = CYC_O;
      tick();
      cyc++;
    end
    check("burst_words_taken", 32'(src_idx), 32'(n_words));
    CYC_I = 1'b0;
    STB_I = 1'b0;
    cyc   = 0;
    while (CYC_O && cyc < 2000) begin
      ACK_I = ($urandom_range(99) >= stall);
      tick();
      cyc++;
    end
    check("drain_cyc_o", {31'd0, CYC_O}, 32'd0);
    ACK_I = 1'b1;
    tick();
    tick();
    check("stream_len", 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      if (cap_q[i] !== exp_q[i]) check($sformatf("stream_word_%0d", i), cap_q[i], exp_q[i]);
      else n_checks++;
    end
  endtask

  initial begin
    int   fa, fs;
    logic c1;

    // Hand-computed: PIL_SEQ[7:0] = 0x86, [15:8] = 0x2D; data k = {k, -k}
    tbl[0]  = '{0, WP};            tbl[1]  = '{1, WN};
    tbl[2]  = '{2, WN};            tbl[3]  = '{3, WP};
    tbl[4]  = '{4, WP};            tbl[5]  = '{5, WP};
    tbl[6]  = '{6, WP};            tbl[7]  = '{7, WN};
    tbl[8]  = '{8, 32'h0000_0000}; tbl[9]  = '{9, 32'h0001_FFFF};
    tbl[10] = '{10, 32'h0002_FFFE}; tbl[11] = '{108, 32'h0064_FF9C};
    tbl[12] = '{199, 32'h00BF_FF41};
    tbl_s1[0] = '{200, WN}; tbl_s1[1] = '{201, WP};
    tbl_s1[2] = '{202, WN}; tbl_s1[3] = '{203, WN};
    tbl_s1[4] = '{204, WP}; tbl_s1[5] = '{205, WN};
    tbl_s1[6] = '{206, WP}; tbl_s1[7] = '{207, WP};

    RST_I = 1'b0;
    CYC_I = 1'b0;
    STB_I = 1'b0;
    WE_I  = 1'b1;
    ACK_I = 1'b1;
    DAT_I = '0;
    #1;
    check("rst_dat_o", DAT_O, 32'd0);
    check("rst_stb_o", {31'd0, STB_O}, 32'd0);
    check("rst_cyc_o", {31'd0, CYC_O}, 32'd0);
    check("rst_ack_o", {31'd0, ACK_O}, 32'd0);
    repeat (3) tick();
    RST_I = 1'b1;
    repeat (2) tick();
    check("idle_stb_o", {31'd0, STB_O}, 32'd0);
    check("idle_we_o", {31'd0, WE_O}, 32'd0);

    // Single symbol, no stalls
    run_burst(192, 0, 0, fa, fs, c1);
    check("first_ack_cycle", 32'(fa), 32'd8);
    check("first_stb_cycle", 32'(fs), 32'd1);
    check("cyc_o_after_start", {31'd0, c1}, 32'd1);
    foreach (tbl[i]) check($sformatf("tbl_pos_%0d", tbl[i].pos), cap_q[tbl[i].pos], tbl[i].exp);

    // 17 symbols in one burst: continuity and wrap of the pilot index
    run_burst(17 * 192, 0, 0, fa, fs, c1);
    foreach (tbl_s1[i]) check($sformatf("sym1_pilot_%0d", i), cap_q[tbl_s1[i].pos], tbl_s1[i].exp);
    for (int j = 0; j < 8; j++) check($sformatf("sym16_pilot_%0d", j), cap_q[16 * 200 + j], tbl[j].exp);

    // Downstream backpressure and upstream gaps
    run_burst(192, 50, 0, fa, fs, c1);
    run_burst(192, 0, 40, fa, fs, c1);
    run_burst(384, 30, 30, fa, fs, c1);

    // Burst dropped after 50 data words, then a fresh burst from pilot 0
    run_burst(50, 0, 0, fa, fs, c1);
    run_burst(192, 0, 0, fa, fs, c1);
    check("restart_first_stb", 32'(fs), 32'd1);
    check("restart_cyc_o", {31'd0, c1}, 32'd1);
    check("restart_pilot0", cap_q[0], tbl[0].exp);
    check("restart_pilot1", cap_q[1], tbl[1].exp);

    // Asynchronous reset in the middle of DATA
    CYC_I = 1'b1;
    STB_I = 1'b1;
    ACK_I = 1'b1;
    for (int i = 0; i < 20; i++) begin
      DAT_I = 32'h1234_0000 + 32'(i);
      tick();
    end
    check("pre_reset_ack", {31'd0, ACK_O}, 32'd1);
    #2;
    RST_I = 1'b0;
    #1;
    check("async_rst_dat_o", DAT_O, 32'd0);
    check("async_rst_stb_o", {31'd0, STB_O}, 32'd0);
    check("async_rst_cyc_o", {31'd0, CYC_O}, 32'd0);
    check("async_rst_we_o", {31'd0, WE_O}, 32'd0);
    check("async_rst_ack_o", {31'd0, ACK_O}, 32'd0);
    repeat (2) tick();
    // CYC_I still high at release must not look like a start
    RST_I = 1'b1;
    repeat (4) tick();
    check("no_start_stb_o", {31'd0, STB_O}, 32'd0);
    check("no_start_cyc_o", {31'd0, CYC_O}, 32'd0);
    CYC_I = 1'b0;
    STB_I = 1'b0;
    repeat (2) tick();
    run_burst(192, 0, 0, fa, fs, c1);
    check("post_rst_first_ack", 32'(fa), 32'd8);
    check("post_rst_first_stb", 32'(fs), 32'd1);
    check("post_rst_pilot7", cap_q[7], tbl[7].exp);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
